// File: rtl/wrap_cascade_pkg.sv
// Shared types and default widths for the wrap-cascade stage and its wrap detector.
package wrap_cascade_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int HI_W_DEF  = 8;

    typedef enum logic {
        SNAP_IDLE,
        SNAP_HOLD
    } snap_state_t;

    // Snapshot layout at the default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic [HI_W_DEF-1:0]  hi;
        logic [CNT_W_DEF-1:0] lo;
    } snap_t;

endpackage

// File: rtl/wrap_detect.sv
// Flags the max -> 0 transition of an upstream binary counter; other jumps to 0 are ignored.
module wrap_detect
    import wrap_cascade_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             wrap
);

    logic [CNT_W-1:0] prev_q;
    logic             prev_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q  <= '0;
            prev_ok <= 1'b0;
        end else begin
            prev_q  <= cnt_in;
            prev_ok <= 1'b1;
        end
    end

    // prev_ok masks the reset value of prev_q so the first sample never counts as a wrap.
    assign wrap = prev_ok && (prev_q == '1) && (cnt_in == '0);

endmodule

// File: rtl/wrap_cascade_stage.sv
// High-order wrap counter with terminal pulse and a valid/ready snapshot port.
module wrap_cascade_stage
    import wrap_cascade_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int HI_W  = HI_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [CNT_W-1:0]      cnt_in,
    input  logic                  hi_en,
    input  logic [HI_W-1:0]       term,
    output logic [HI_W-1:0]       hi_cnt,
    output logic                  tc_pulse,
    input  logic                  snap_req,
    output logic                  snap_vld,
    input  logic                  snap_rdy,
    output logic [HI_W+CNT_W-1:0] snap_data,
    output logic                  ovr,
    input  logic                  ovr_clr
);

    typedef struct packed {
        logic [HI_W-1:0]  hi;
        logic [CNT_W-1:0] lo;
    } snap_word_t;

    logic        wrap;
    logic        hi_step;
    logic        term_hit;
    logic [HI_W-1:0] hi_nxt;
    snap_word_t  snap_nxt;

    snap_state_t state;
    snap_state_t state_nxt;
    logic        capture;
    logic        ovr_set;

    wrap_detect #(
        .CNT_W (CNT_W)
    ) u_wrap_detect (
        .clk    (clk),
        .resetn (resetn),
        .cnt_in (cnt_in),
        .wrap   (wrap)
    );

    assign hi_step  = wrap && hi_en;
    // >= rather than == so lowering term below the current count still wraps.
    assign term_hit = hi_step && (hi_cnt >= term);

    always_comb begin
        hi_nxt = hi_cnt;
        if (hi_step) begin
            hi_nxt = term_hit ? '0 : hi_cnt + HI_W'(1);
        end
    end

    // Capture uses hi_nxt so a snapshot on the wrap edge reads {new hi, 0}.
    assign snap_nxt = '{hi: hi_nxt, lo: cnt_in};

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    capture   = 1'b1;
                    state_nxt = SNAP_HOLD;
                end
            end
            SNAP_HOLD: begin
                if (snap_rdy) begin
                    if (snap_req) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = SNAP_IDLE;
                    end
                end else if (snap_req) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_nxt = SNAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_cnt    <= '0;
            tc_pulse  <= 1'b0;
            state     <= SNAP_IDLE;
            snap_data <= '0;
            ovr       <= 1'b0;
        end else begin
            hi_cnt   <= hi_nxt;
            tc_pulse <= term_hit;
            state    <= state_nxt;
            if (capture) begin
                snap_data <= snap_nxt;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    assign snap_vld = (state == SNAP_HOLD);

endmodule

// File: tb/tb_wrap_cascade_stage.sv
// Directed scenarios plus a randomized run checked against a cycle-level behavioural model.
module tb_wrap_cascade_stage;

    localparam int CNT_W = 4;
    localparam int HI_W  = 8;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic [CNT_W-1:0]      cnt_in = '0;
    logic                  hi_en = 1'b0;
    logic [HI_W-1:0]       term = '0;
    logic [HI_W-1:0]       hi_cnt;
    logic                  tc_pulse;
    logic                  snap_req = 1'b0;
    logic                  snap_vld;
    logic                  snap_rdy = 1'b0;
    logic [HI_W+CNT_W-1:0] snap_data;
    logic                  ovr;
    logic                  ovr_clr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // behavioural model state
    int                    m_prev = 0;
    bit                    m_prev_ok = 0;
    int                    m_hi = 0;
    bit                    m_tc = 0;
    bit                    m_vld = 0;
    logic [HI_W+CNT_W-1:0] m_data = '0;
    bit                    m_ovr = 0;

    wrap_cascade_stage #(
        .CNT_W (CNT_W),
        .HI_W  (HI_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cnt_in    (cnt_in),
        .hi_en     (hi_en),
        .term      (term),
        .hi_cnt    (hi_cnt),
        .tc_pulse  (tc_pulse),
        .snap_req  (snap_req),
        .snap_vld  (snap_vld),
        .snap_rdy  (snap_rdy),
        .snap_data (snap_data),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // One clock edge: the model consumes the inputs presented at that edge, outputs are sampled 1ns later.
    task automatic tick();
        int  cur;
        int  new_hi;
        bit  is_wrap;
        bit  drop;
        @(posedge clk);
        cur = int'(cnt_in);
        if (!resetn) begin
            m_prev = 0; m_prev_ok = 0; m_hi = 0; m_tc = 0;
            m_vld = 0; m_data = '0; m_ovr = 0;
        end else begin
            is_wrap = m_prev_ok && (m_prev == (1 << CNT_W) - 1) && (cur == 0);
            new_hi = m_hi;
            m_tc = 0;
            if (is_wrap && hi_en) begin
                if (m_hi >= int'(term)) begin
                    new_hi = 0;
                    m_tc = 1;
                end else begin
                    new_hi = m_hi + 1;
                end
            end
            drop = 0;
            if (!m_vld || snap_rdy) begin
                if (snap_req) begin
                    m_vld = 1;
                    m_data = {HI_W'(new_hi), CNT_W'(cur)};
                end else begin
                    m_vld = 0;
                end
            end else if (snap_req) begin
                drop = 1;
            end
            if (drop) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            m_hi = new_hi;
            m_prev = cur;
            m_prev_ok = 1;
        end
        #1;
    endtask

    task automatic wrap_seq();
        cnt_in = 4'd15; tick();
        cnt_in = 4'd0;  tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; cnt_in = 4'd15;
        repeat (3) tick();
        tests_run++;
        if ({hi_cnt, tc_pulse, snap_vld, snap_data, ovr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got hi=%0d tc=%0b vld=%0b data=%h ovr=%0b want all 0",
                     hi_cnt, tc_pulse, snap_vld, snap_data, ovr);
        end
        resetn = 1'b1; cnt_in = 4'd0;
        tick();
        tests_run++;
        if (tc_pulse !== 1'b0 || hi_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_first_sample got tc=%0b hi=%0d want tc=0 hi=0", tc_pulse, hi_cnt);
        end
    endtask

    task automatic test_counting();
        int exp_hi[3] = '{1, 2, 0};
        term = 8'd2; hi_en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int v = 1; v < 16; v++) begin
                cnt_in = CNT_W'(v); tick();
            end
            cnt_in = 4'd0; tick();
            tests_run++;
            if (hi_cnt !== HI_W'(exp_hi[w]) || tc_pulse !== (w == 2)) begin
                tests_failed++;
                $display("FAIL count_wrap%0d got hi=%0d tc=%0b want hi=%0d tc=%0b",
                         w, hi_cnt, tc_pulse, exp_hi[w], (w == 2));
            end
        end
        cnt_in = 4'd1; tick();
        tests_run++;
        if (tc_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL tc_one_cycle got tc=%0b want 0", tc_pulse);
        end
    endtask

    task automatic test_false_wrap();
        logic [HI_W-1:0] h0;
        wrap_seq();
        h0 = 8'd1;
        tests_run++;
        if (hi_cnt !== h0) begin
            tests_failed++;
            $display("FAIL false_pre got hi=%0d want %0d", hi_cnt, h0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            hi_en = (pass == 0);
            cnt_in = 4'd7; tick();
            cnt_in = 4'd0; tick();
            tests_run++;
            if (hi_cnt !== h0 || tc_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL false_7to0 en=%0b got hi=%0d tc=%0b want hi=%0d tc=0", hi_en, hi_cnt, tc_pulse, h0);
            end
            cnt_in = 4'd15; tick();
            cnt_in = 4'd3;  tick();
            tests_run++;
            if (hi_cnt !== h0 || tc_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL false_15to3 en=%0b got hi=%0d tc=%0b want hi=%0d tc=0", hi_en, hi_cnt, tc_pulse, h0);
            end
        end
        wrap_seq();
        tests_run++;
        if (hi_cnt !== h0 || tc_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL hi_en_off_wrap got hi=%0d tc=%0b want hi=%0d tc=0", hi_cnt, tc_pulse, h0);
        end
        hi_en = 1'b1;
    endtask

    task automatic test_term_change();
        term = 8'd200;
        for (int i = 0; i < 20 && hi_cnt != 8'd5; i++) wrap_seq();
        tests_run++;
        if (hi_cnt !== 8'd5) begin
            tests_failed++;
            $display("FAIL term_setup got hi=%0d want 5", hi_cnt);
        end
        term = 8'd3;
        wrap_seq();
        tests_run++;
        if (hi_cnt !== 8'd0 || tc_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL term_lowered got hi=%0d tc=%0b want hi=0 tc=1", hi_cnt, tc_pulse);
        end
    endtask

    task automatic test_snapshot();
        resetn = 1'b0; tick();
        resetn = 1'b1; term = 8'd9; hi_en = 1'b1; snap_rdy = 1'b0;
        repeat (4) wrap_seq();
        tests_run++;
        if (hi_cnt !== 8'd4 || snap_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_setup got hi=%0d vld=%0b want hi=4 vld=0", hi_cnt, snap_vld);
        end
        cnt_in = 4'd15; tick();
        cnt_in = 4'd0; snap_req = 1'b1; tick();
        snap_req = 1'b0;
        tests_run++;
        if (snap_data !== 12'h050 || snap_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL snap_coherent got data=%h vld=%0b want data=050 vld=1", snap_data, snap_vld);
        end
        cnt_in = 4'd1; tick();
        tests_run++;
        if (snap_data !== 12'h050 || snap_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL snap_hold got data=%h vld=%0b want data=050 vld=1", snap_data, snap_vld);
        end
    endtask

    task automatic test_backpressure();
        cnt_in = 4'd2; snap_req = 1'b1; snap_rdy = 1'b0; tick();
        tests_run++;
        if (snap_data !== 12'h050 || ovr !== 1'b1 || snap_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drop got data=%h ovr=%0b vld=%0b want data=050 ovr=1 vld=1", snap_data, ovr, snap_vld);
        end
        cnt_in = 4'd3; ovr_clr = 1'b1; tick();
        tests_run++;
        if (ovr !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_set_priority got ovr=%0b want 1", ovr);
        end
        cnt_in = 4'd6; ovr_clr = 1'b0; snap_rdy = 1'b1; tick();
        tests_run++;
        if (snap_data !== 12'h056 || snap_vld !== 1'b1 || ovr !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_recapture got data=%h vld=%0b ovr=%0b want data=056 vld=1 ovr=1", snap_data, snap_vld, ovr);
        end
        cnt_in = 4'd7; snap_req = 1'b0; tick();
        tests_run++;
        if (snap_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release got vld=%0b want 0", snap_vld);
        end
        cnt_in = 4'd8; snap_rdy = 1'b0; ovr_clr = 1'b1; tick();
        ovr_clr = 1'b0;
        tests_run++;
        if (ovr !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_clear got ovr=%0b want 0", ovr);
        end
    endtask

    task automatic test_random();
        int c = 0;
        resetn = 1'b0; tick();
        for (int i = 0; i < 600; i++) begin
            resetn   = ($urandom_range(49) != 0);
            c        = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : (c + 1) % 16;
            cnt_in   = CNT_W'(c);
            hi_en    = ($urandom_range(5) != 0);
            term     = HI_W'($urandom_range(4));
            snap_req = $urandom_range(1) != 0;
            snap_rdy = $urandom_range(1) != 0;
            ovr_clr  = ($urandom_range(5) == 0);
            tick();
            tests_run++;
            if (hi_cnt !== HI_W'(m_hi) || tc_pulse !== m_tc || snap_vld !== m_vld ||
                snap_data !== m_data || ovr !== m_ovr) begin
                tests_failed++;
                $display("FAIL random_%0d got hi=%0d tc=%0b vld=%0b data=%h ovr=%0b want hi=%0d tc=%0b vld=%0b data=%h ovr=%0b",
                         i, hi_cnt, tc_pulse, snap_vld, snap_data, ovr, m_hi, m_tc, m_vld, m_data, m_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_false_wrap();
        test_term_change();
        test_snapshot();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
